systolic_seq_ctrl: RTL

Sequencer for the square weight-stationary PE array in the MMU. Each job has three phases. It first preloads ARRAY_DIM weight rows from the weight buffer. It then streams a programmable number of ifmap vectors with per-row diagonal skew, and finally drains the array while flagging per-column psum validity. It drives the PE-array enables (weight_en, ifmap_en, psum_en) and the buffer read ports, and it reports job completion to the top-level controller.

---
 rtl/systolic_seq_ctrl.sv | 103 ++++++++++
 1 files changed

// File: rtl/systolic_seq_ctrl.sv
// systolic_seq_ctrl: sequences weight preload, skewed ifmap streaming and drain for a square
// weight-stationary PE array; every output comes straight from a flop.
module systolic_seq_ctrl #(
  parameter int ARRAY_DIM     = 8,
  parameter int VEC_CNT_WIDTH = 8,
  parameter int ADDR_WIDTH    = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start_i,
  input  logic [VEC_CNT_WIDTH-1:0] vec_num_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     w_rd_en_o,
  output logic [ADDR_WIDTH-1:0]    w_addr_o,
  output logic                     weight_en_o,
  output logic                     ifmap_rd_en_o,
  output logic [ADDR_WIDTH-1:0]    ifmap_addr_o,
  output logic [ARRAY_DIM-1:0]     ifmap_en_o,
  output logic                     psum_en_o,
  output logic [ARRAY_DIM-1:0]     ofmap_valid_o
);
  localparam int DW = $clog2(2 * ARRAY_DIM);
  localparam logic [ADDR_WIDTH-1:0] LAST_W = ADDR_WIDTH'(ARRAY_DIM - 1);
  localparam logic [DW-1:0] DRAIN_INIT = DW'(2 * ARRAY_DIM - 1);

  typedef enum logic [2:0] {IDLE, LOAD_W, FEED, DRAIN, DONE} state_e;

  state_e                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]  last_q, last_d;
  logic [ADDR_WIDTH-1:0]  w_addr_q, w_addr_d;
  logic [ADDR_WIDTH-1:0]  i_addr_q, i_addr_d;
  logic [DW-1:0]          drain_q, drain_d;
  logic [2*ARRAY_DIM-1:0] skew_q;
  logic                   w_rd_en_q, weight_en_q, i_rd_en_q, busy_q, done_q;

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    w_addr_d = w_addr_q;
    i_addr_d = i_addr_q;
    drain_d  = drain_q;
    unique case (state_q)
      IDLE: if (start_i && vec_num_i != '0) begin
        state_d  = LOAD_W;
        last_d   = ADDR_WIDTH'(vec_num_i) - ADDR_WIDTH'(1);
        w_addr_d = '0;
      end
      LOAD_W: if (w_addr_q == LAST_W) begin
        state_d  = FEED;
        i_addr_d = '0;
      end else w_addr_d = w_addr_q + 1'b1;
      FEED: if (i_addr_q == last_q) begin
        state_d = DRAIN;
        drain_d = DRAIN_INIT;
      end else i_addr_d = i_addr_q + 1'b1;
      DRAIN:   state_d = (drain_q == '0) ? DONE : DRAIN;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (state_q == DRAIN && drain_q != '0) drain_d = drain_q - 1'b1;
  end

  // skew_q[k] is the ifmap read enable delayed k+1 cycles: rows use 0..N-1, columns N..2N-1
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= '0;
      w_addr_q    <= '0;
      i_addr_q    <= '0;
      drain_q     <= '0;
      skew_q      <= '0;
      w_rd_en_q   <= 1'b0;
      weight_en_q <= 1'b0;
      i_rd_en_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      w_addr_q    <= w_addr_d;
      i_addr_q    <= i_addr_d;
      drain_q     <= drain_d;
      skew_q      <= {skew_q[2*ARRAY_DIM-2:0], i_rd_en_q};
      w_rd_en_q   <= state_d == LOAD_W;
      weight_en_q <= w_rd_en_q;
      i_rd_en_q   <= state_d == FEED;
      busy_q      <= state_d != IDLE;
      done_q      <= state_d == DONE;
    end
  end

  assign busy_o        = busy_q;
  assign done_o        = done_q;
  assign w_rd_en_o     = w_rd_en_q;
  assign w_addr_o      = w_addr_q;
  assign weight_en_o   = weight_en_q;
  assign ifmap_rd_en_o = i_rd_en_q;
  assign ifmap_addr_o  = i_addr_q;
  assign ifmap_en_o    = skew_q[ARRAY_DIM-1:0];
  assign psum_en_o     = skew_q[0];
  assign ofmap_valid_o = skew_q[2*ARRAY_DIM-1:ARRAY_DIM];
endmodule
